// File: rtl/eth_tx_arb_pkg.sv
// Shared Ethernet definitions: framing constants, TX scheduler states and
// the byte-wise reflected CRC-32 step used by the MAC-side blocks.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam int          PRE_LEN       = 7;
  localparam int          FCS_LEN       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // The register holds the CRC in reflected form, so bytes enter LSB first.
  function automatic logic [31:0] next_crc32(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic [31:0] poly_r;
    poly_r = reflect32(CRC_POLY);
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// Requester byte streams plus the GMII transmit pins of the TX scheduler.
interface eth_tx_arb_if #(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_err;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               tx_clk;
  logic [7:0]         tx_dat;
  logic               tx_en;
  logic               tx_er;

  modport master (
    output req_valid, req_data, req_last, req_err,
    input  req_ready, grant, tx_clk, tx_dat, tx_en, tx_er
  );

  modport slave (
    input  req_valid, req_data, req_last, req_err,
    output req_ready, grant, tx_clk, tx_dat, tx_en, tx_er
  );

endinterface

// File: rtl/eth_tx_arb_crc32.sv
// Byte-wide Ethernet CRC register; fcs_byte presents the complemented CRC
// one byte at a time, least-significant byte first.
module eth_crc32
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  input  logic [1:0] byte_sel,
  output logic [7:0] fcs_byte
);

  logic [31:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (init) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= next_crc32(crc_q, data);
    end
  end

  assign fcs_byte = ~crc_q[{byte_sel, 3'b000} +: 8];

endmodule

// File: rtl/eth_tx_arb.sv
// GMII TX scheduler: round-robin frame-level arbitration between requesters,
// preamble/SFD insertion, zero padding, FCS append and inter-frame gap.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60
) (
  input logic        clk,
  input logic        rst_n,
  eth_tx_arb_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  tx_state_t        state_q, state_d;
  logic [15:0]      phase_q, phase_d;
  logic [15:0]      cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;

  logic [7:0]       tx_dat_q, tx_dat_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;

  logic             crc_init, crc_en;
  logic [7:0]       crc_data;
  logic [7:0]       fcs_byte;

  logic             cur_valid, cur_last, cur_err;
  logic [7:0]       cur_data;

  assign cur_valid = bus.req_valid[gidx_q];
  assign cur_last  = bus.req_last[gidx_q];
  assign cur_err   = bus.req_err[gidx_q];
  assign cur_data  = bus.req_data[{gidx_q, 3'b000} +: 8];
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // First valid requester at or after the rotating pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && bus.req_valid[PTR_W'((int'(ptr_q) + k) % N_REQ)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  eth_crc32 u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (crc_init),
    .en       (crc_en),
    .data     (crc_data),
    .byte_sel (phase_q[1:0]),
    .fcs_byte (fcs_byte)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    tx_dat_d = 8'h00;
    tx_en_d  = 1'b0;
    tx_er_d  = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_data = 8'h00;

    case (state_q)
      ST_IDLE: begin
        crc_init = 1'b1;
        cnt_d    = '0;
        err_d    = 1'b0;
        if (pick_found) begin
          state_d           = ST_PRE;
          phase_d           = '0;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          ptr_d             = PTR_W'((int'(pick_idx) + 1) % N_REQ);
        end
      end

      ST_PRE: begin
        tx_en_d  = 1'b1;
        tx_dat_d = PREAMBLE_BYTE;
        if (phase_q == 16'(PRE_LEN - 1)) begin
          state_d = ST_SFD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      ST_SFD: begin
        tx_en_d  = 1'b1;
        tx_dat_d = SFD_BYTE;
        state_d  = ST_DATA;
      end

      // An underrun still occupies a wire cycle but never reaches the CRC.
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (cur_valid) begin
          tx_dat_d = cur_data;
          tx_er_d  = err_q | cur_err;
          err_d    = err_q | cur_err;
          crc_en   = 1'b1;
          crc_data = cur_data;
          cnt_d    = cnt_inc;
          if (cur_last) begin
            state_d = (int'({16'd0, cnt_inc}) < MIN_LEN) ? ST_PAD : ST_FCS;
            phase_d = '0;
          end
        end else begin
          tx_dat_d = 8'h00;
          tx_er_d  = 1'b1;
          err_d    = 1'b1;
        end
      end

      ST_PAD: begin
        tx_en_d  = 1'b1;
        tx_er_d  = err_q;
        crc_en   = 1'b1;
        cnt_d    = cnt_inc;
        if (int'({16'd0, cnt_inc}) >= MIN_LEN) begin
          state_d = ST_FCS;
          phase_d = '0;
        end
      end

      ST_FCS: begin
        tx_en_d  = 1'b1;
        tx_er_d  = err_q;
        tx_dat_d = fcs_byte;
        if (phase_q == 16'(FCS_LEN - 1)) begin
          state_d = (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;
          phase_d = '0;
          grant_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      // The IDLE cycle that follows supplies the last idle wire cycle.
      ST_IFG: begin
        crc_init = 1'b1;
        err_d    = 1'b0;
        if (phase_q == 16'(IFG_CYCLES - 2)) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      tx_dat_q <= 8'h00;
      tx_en_q  <= 1'b0;
      tx_er_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      tx_dat_q <= tx_dat_d;
      tx_en_q  <= tx_en_d;
      tx_er_q  <= tx_er_d;
    end
  end

  assign bus.tx_clk    = clk;
  assign bus.tx_dat    = tx_dat_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.tx_er     = tx_er_q;
  assign bus.grant     = grant_q;
  assign bus.req_ready = (state_q == ST_DATA) ? grant_q : '0;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomized bench for eth_tx_arb: frames on the GMII side are compared with
// a frame-level reference model (framing, padding, FCS, tx_er, arbitration).
module tb_eth_tx_arb;

  localparam int N   = 2;
  localparam int IFG = 12;
  localparam int MIN = 60;

  logic clk;
  logic rst_n;

  eth_tx_arb_if #(.N_REQ(N)) bus ();
  eth_tx_arb_if #(.N_REQ(N)) bus0 ();

  eth_tx_arb #(.N_REQ(N), .IFG_CYCLES(IFG), .MIN_LEN(MIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  eth_tx_arb #(.N_REQ(N), .IFG_CYCLES(IFG), .MIN_LEN(0)) dut_nopad (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[N][$];
  int         exp_len[N][$];
  int         gap_q[$];
  int         grant_log[$];
  int         model_ptr = 0;
  bit         raw_ok = 1'b0;
  int         idle_bad = 0;
  bit         in_frame = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, req);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] modelCrc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Expected wire image of one frame as {tx_er, tx_dat} words.
  task automatic buildExpected(input int r, input logic [7:0] pl[$],
                               input int err_idx, input int gap_pos, input int gap_len);
    logic [31:0] crc;
    bit          err;
    int          n;
    crc = 32'hFFFF_FFFF;
    err = 1'b0;
    n   = 0;
    repeat (7) begin exp_q[r].push_back({1'b0, 8'h55}); n++; end
    exp_q[r].push_back({1'b0, 8'hD5}); n++;
    for (int i = 0; i < pl.size(); i++) begin
      if (i == gap_pos) begin
        repeat (gap_len) begin err = 1'b1; exp_q[r].push_back({1'b1, 8'h00}); n++; end
      end
      if (i == err_idx) err = 1'b1;
      exp_q[r].push_back({err, pl[i]}); n++;
      crc = modelCrc(crc, pl[i]);
    end
    for (int c = pl.size(); c < MIN; c++) begin
      exp_q[r].push_back({err, 8'h00}); n++;
      crc = modelCrc(crc, 8'h00);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) begin
      exp_q[r].push_back({err, crc[8*k +: 8]}); n++;
    end
    exp_len[r].push_back(n);
  endtask

  task automatic waitReady(input int r);
    int t;
    t = 0;
    while (!bus.req_ready[r] && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) checkOutput($sformatf("ready_timeout_r%0d", r), 0, 1);
  endtask

  // Call at a negedge; returns at the negedge after the last handshake.
  task automatic applyStimulus(input int r, input logic [7:0] pl[$],
                               input int err_idx, input int gap_pos, input int gap_len);
    buildExpected(r, pl, err_idx, gap_pos, gap_len);
    for (int i = 0; i < pl.size(); i++) begin
      if (i == gap_pos && gap_len > 0) begin
        bus.req_valid[r] = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      bus.req_valid[r]        = 1'b1;
      bus.req_data[8*r +: 8]  = pl[i];
      bus.req_last[r]         = (i == pl.size() - 1);
      bus.req_err[r]          = (i == err_idx);
      waitReady(r);
      @(negedge clk);
    end
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
    bus.req_err[r]   = 1'b0;
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((exp_len[0].size() > 0 || exp_len[1].size() > 0 || in_frame) && t < 6000) begin
      @(negedge clk); t++;
    end
    if (t >= 6000) checkOutput("drain_timeout", 1, 0);
    repeat (16) @(negedge clk);
  endtask

  // Frame monitor: collects each tx_en burst and scores it against the model.
  initial begin
    logic [8:0]       cur[$];
    int               owner;
    int               low_cnt;
    int               fnum;
    logic [N-1:0]     g_start, rdy_pre, rdy_sfd;
    owner = -1; low_cnt = 0; fnum = 0;
    g_start = '0; rdy_pre = '0; rdy_sfd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 1'b0;
        cur.delete();
        low_cnt   = 0;
        model_ptr = 0;
      end else if (bus.tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur.delete();
          gap_q.push_back(low_cnt);
          g_start = bus.grant;
          grant_log.push_back(int'(bus.grant));
          owner = -1;
          for (int k = 0; k < N; k++) begin
            if (owner < 0 && exp_len[(model_ptr + k) % N].size() > 0) owner = (model_ptr + k) % N;
          end
          if (owner >= 0) model_ptr = (owner + 1) % N;
          else if (!raw_ok) checkOutput("unexpected_frame", 1, 0);
        end
        cur.push_back({bus.tx_er, bus.tx_dat});
        if (cur.size() == 7) rdy_pre = bus.req_ready;
        if (cur.size() == 8) rdy_sfd = bus.req_ready;
      end else begin
        if (bus.tx_er || bus.tx_dat != 8'h00) idle_bad++;
        if (in_frame) begin
          in_frame = 1'b0;
          low_cnt  = 0;
          if (owner >= 0) begin
            int elen, nbad, first_bad;
            logic [31:0] fcs_o, fcs_e;
            elen = exp_len[owner].pop_front();
            nbad = 0; first_bad = -1;
            fcs_o = '0; fcs_e = '0;
            for (int i = 0; i < elen; i++) begin
              if (i >= cur.size() || cur[i] !== exp_q[owner][i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
              end
            end
            for (int k = 0; k < 4; k++) begin
              if (cur.size() >= 4) fcs_o[8*k +: 8] = cur[cur.size() - 4 + k][7:0];
              fcs_e[8*k +: 8] = exp_q[owner][elen - 4 + k][7:0];
            end
            checkOutput($sformatf("frame%0d_grant", fnum), 32'(g_start), 32'(1 << owner));
            checkOutput($sformatf("frame%0d_len", fnum), cur.size(), elen);
            checkOutput($sformatf("frame%0d_bad_words(first %0d)", fnum, first_bad), nbad, 0);
            checkOutput($sformatf("frame%0d_fcs", fnum), fcs_o, fcs_e);
            checkOutput($sformatf("frame%0d_ready_pre", fnum), 32'(rdy_pre), 0);
            checkOutput($sformatf("frame%0d_ready_sfd", fnum), 32'(rdy_sfd), 32'(1 << owner));
            repeat (elen) void'(exp_q[owner].pop_front());
            fnum++;
          end
        end
        low_cnt++;
      end
    end
  end

  task automatic crcVectorTest();
    logic [7:0] vec[9];
    logic [7:0] cap[$];
    bit         er_seen;
    logic [31:0] fcs;
    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    er_seen = 1'b0;
    fork
      begin
        int t;
        for (int i = 0; i < 9; i++) begin
          bus0.req_valid[0]    = 1'b1;
          bus0.req_data[7:0]   = vec[i];
          bus0.req_last[0]     = (i == 8);
          t = 0;
          while (!bus0.req_ready[0] && t < 200) begin @(negedge clk); t++; end
          if (t >= 200) checkOutput("crc_ready_timeout", 0, 1);
          @(negedge clk);
        end
        bus0.req_valid[0] = 1'b0;
        bus0.req_last[0]  = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!bus0.tx_en && t < 200) begin @(negedge clk); t++; end
        while (bus0.tx_en && cap.size() < 100) begin
          cap.push_back(bus0.tx_dat);
          if (bus0.tx_er) er_seen = 1'b1;
          @(negedge clk);
        end
      end
    join
    fcs = (cap.size() == 21) ? {cap[20], cap[19], cap[18], cap[17]} : 32'h0;
    checkOutput("crc_vec_len", cap.size(), 21);
    checkOutput("crc_vec_sfd", (cap.size() > 7) ? 32'(cap[7]) : 32'hFFFF, 32'hD5);
    checkOutput("crc_vec_byte0", (cap.size() > 8) ? 32'(cap[8]) : 32'hFFFF, 32'h31);
    checkOutput("crc_vec_fcs", fcs, 32'hCBF4_3926);
    checkOutput("crc_vec_tx_er", 32'(er_seen), 0);
  endtask

  initial begin
    #400_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    rst_n = 1'b0;
    bus.req_valid  = '0; bus.req_data  = '0; bus.req_last  = '0; bus.req_err  = '0;
    bus0.req_valid = '0; bus0.req_data = '0; bus0.req_last = '0; bus0.req_err = '0;
    #22;
    checkOutput("reset_tx_en", 32'(bus.tx_en), 0);
    checkOutput("reset_tx_er", 32'(bus.tx_er), 0);
    checkOutput("reset_tx_dat", 32'(bus.tx_dat), 0);
    checkOutput("reset_ready", 32'(bus.req_ready), 0);
    checkOutput("reset_grant", 32'(bus.grant), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    crcVectorTest();

    $display("[TB] padding and request latency");
    pa.delete();
    for (int i = 0; i < 10; i++) pa.push_back(8'(i));
    fork
      applyStimulus(1, pa, -1, -1, 0);
      begin
        @(negedge clk);
        checkOutput("latency_tx_en_early", 32'(bus.tx_en), 0);
        checkOutput("latency_grant", 32'(bus.grant), 32'h2);
        @(negedge clk);
        checkOutput("latency_tx_en", 32'(bus.tx_en), 1);
        checkOutput("latency_pre_dat", 32'(bus.tx_dat), 32'h55);
      end
    join
    waitDrain();

    $display("[TB] error propagation");
    pa.delete();
    repeat (20) pa.push_back(8'($urandom));
    applyStimulus(0, pa, 5, -1, 0);
    waitDrain();

    $display("[TB] underrun");
    pa.delete();
    repeat (20) pa.push_back(8'($urandom));
    applyStimulus(1, pa, -1, 10, 2);
    waitDrain();

    $display("[TB] arbitration");
    gap_q.delete();
    grant_log.delete();
    pa.delete();
    pb.delete();
    repeat (64) pa.push_back(8'($urandom));
    repeat (64) pb.push_back(8'($urandom));
    fork
      begin
        applyStimulus(0, pa, -1, -1, 0);
        applyStimulus(0, pb, -1, -1, 0);
      end
      applyStimulus(1, pb, -1, -1, 0);
    join
    waitDrain();
    checkOutput("arb_frames", gap_q.size(), 3);
    checkOutput("arb_grant0", (grant_log.size() > 0) ? 32'(grant_log[0]) : 0, 1);
    checkOutput("arb_grant1", (grant_log.size() > 1) ? 32'(grant_log[1]) : 0, 2);
    checkOutput("arb_grant2", (grant_log.size() > 2) ? 32'(grant_log[2]) : 0, 1);
    checkOutput("arb_gap1", (gap_q.size() > 1) ? 32'(gap_q[1]) : 0, IFG);
    checkOutput("arb_gap2", (gap_q.size() > 2) ? 32'(gap_q[2]) : 0, IFG);

    $display("[TB] reset mid-frame");
    raw_ok = 1'b1;
    bus.req_valid[0]   = 1'b1;
    bus.req_data[7:0]  = 8'hA5;
    waitReady(0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx_en", 32'(bus.tx_en), 0);
    checkOutput("midreset_tx_er", 32'(bus.tx_er), 0);
    checkOutput("midreset_ready", 32'(bus.req_ready), 0);
    checkOutput("midreset_grant", 32'(bus.grant), 0);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    raw_ok = 1'b0;
    @(negedge clk);
    grant_log.delete();
    pa.delete();
    pb.delete();
    repeat (8) pa.push_back(8'($urandom));
    repeat (8) pb.push_back(8'($urandom));
    fork
      applyStimulus(1, pb, -1, -1, 0);
      applyStimulus(0, pa, -1, -1, 0);
    join
    waitDrain();
    checkOutput("postreset_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 0, 1);

    $display("[TB] randomized frames");
    for (int it = 0; it < 10; it++) begin
      int len_a, len_b, e_a, g_a, gl_a;
      len_a = $urandom_range(1, 90);
      len_b = $urandom_range(1, 90);
      e_a   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len_a - 1) : -1;
      g_a   = -1;
      gl_a  = 0;
      if (len_a >= 2 && $urandom_range(0, 2) == 0) begin
        g_a  = $urandom_range(1, len_a - 1);
        gl_a = $urandom_range(1, 3);
      end
      pa.delete();
      pb.delete();
      repeat (len_a) pa.push_back(8'($urandom));
      repeat (len_b) pb.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        applyStimulus($urandom_range(0, 1), pa, e_a, g_a, gl_a);
      end else begin
        fork
          applyStimulus(0, pa, e_a, g_a, gl_a);
          applyStimulus(1, pb, -1, -1, 0);
        join
      end
      waitDrain();
    end

    checkOutput("idle_outputs_clean", idle_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_arb.md
# eth_tx_arb

Synthesizable GMII transmit scheduler that shares one GMII TX port between `N_REQ` byte-stream requesters. It arbitrates round-robin at frame boundaries. It frames each granted packet with a 7-byte preamble, the SFD, zero padding and the Ethernet FCS, and enforces the inter-frame gap. It sits between the packet-building logic and the PHY-facing GMII pins. It is the synthesizable counterpart of the team's behavioral packet generators.

## Interface
- `N_REQ`, 2: number of requesters (1..8).
- `IFG_CYCLES`, 12: minimum idle cycles with `tx_en`=0 between frames (≥1).
- `MIN_LEN`, 60: minimum payload bytes before FCS. Shorter payloads are zero-padded. 0 disables padding.
- `clk`  in  1  system/GMII clock, 125 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  8·N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- `req_last`  in  N_REQ  marks the final payload byte.
- `req_err`  in  N_REQ  marks the byte as errored.
- `req_ready`  out  N_REQ  byte accepted when valid&ready; at most one bit high.
- `grant`  out  N_REQ  one-hot owner of the current frame; 0 when idle.
- `tx_clk`  out  1  equals `clk` (combinational passthrough).
- `tx_dat`  out  8  GMII TXD, registered.
- `tx_en`  out  1  GMII TX_EN, registered.
- `tx_er`  out  1  GMII TX_ER, registered.

## Operation
- States: IDLE → PRE → SFD → DATA → (PAD) → FCS → IFG → IDLE.
- **IDLE:** if any `req_valid` is high, grant the first valid requester at or after the rotating pointer, then go to PRE. The pointer becomes grant+1 mod N_REQ. `grant` is held until IFG is entered.
- **PRE:** drives 0x55 for 7 cycles.
- **SFD:** drives 0xD5 for 1 cycle.
- **DATA:** `req_ready[g]` is high; each handshake moves `req_data` to `tx_dat` on the next cycle. The CRC is updated (init 0xFFFFFFFF, reflected CRC-32, poly 0x04C11DB7) and the 16-bit payload counter increments, saturating.
  - Handshake with `req_last`: go to PAD if count+1 < MIN_LEN, else FCS.
- **Underrun:** `req_valid[g]`=0 in a DATA cycle drives 0x00 with `tx_er`=1 and sets the sticky error flag. That byte is not counted or CRC'd, and the state stays in DATA.
- **Sticky error:** `req_err` on a byte, or an underrun, sets the flag. Once set, `tx_er`=1 from that byte through the last FCS byte, matching the generators' erridx behavior. The flag clears in IFG.
- **PAD:** drives 0x00 bytes, CRC'd and counted, until count = MIN_LEN, then FCS.
- **FCS:** drives 4 bytes, the complement of the final CRC, least-significant byte first with Ethernet bit order.
- **IFG:** `tx_en`=0, `tx_er`=0, `tx_dat`=0 for IFG_CYCLES cycles, then IDLE. Requests are ignored in IFG.
- A requester dropping `req_valid` in IDLE before grant is not penalized. Only the pointer matters.

## Timing
- **Reset (async, immediate):** `tx_en`=0, `tx_er`=0, `tx_dat`=0x00, `req_ready`=0, `grant`=0, pointer=0, CRC=0xFFFFFFFF, state IDLE.
  - Reset mid-frame truncates the frame on the PHY. No recovery sequence.
- **Request to first preamble byte:** `req_valid` sampled high in IDLE at edge t gives `tx_en`=1, `tx_dat`=0x55 after edge t+1.
- **SFD:** present on `tx_dat` in the 8th cycle of `tx_en`.
- **`req_ready[g]`:** high in the same cycle 0xD5 is on `tx_dat`, so payload follows the SFD with no bubble. It drops the cycle after the `req_last` handshake.
- **Frame length:** `tx_en` high for exactly 8 + max(len, MIN_LEN) + 4 cycles, with no underruns.
- **Back-to-back:** the next frame's preamble starts IFG_CYCLES+1 cycles after the last FCS byte (one cycle in IDLE).
- **Simultaneous requests:** priority goes to the pointer, so with both valid continuously, grants alternate 0,1,0,1.

## Structure
- **Package `eth_pkg`:** holds the preamble/SFD constants (0x55, 0xD5), CRC init/poly, the state enum, and the byte-wise `next_crc32` function shared with other Ethernet blocks.
- **Sub-module `eth_crc32`:** byte-wide CRC register with init/enable/data inputs and an FCS byte output. The arbiter/FSM and output registers stay in `eth_tx_arb`.

## Test plan
- **CRC check vector:** MIN_LEN=0, requester 0 sends ASCII "123456789" → 0x55×7, 0xD5, 31..39, then FCS bytes 0x26 0x39 0xF4 0xCB; `tx_en` high 21 cycles.
- **Padding:** requester 1 sends 10 bytes 0x00..0x09 with default MIN_LEN → 50 pad bytes of 0x00, then FCS; `tx_en` high 72 cycles; FCS matches the reference-model CRC.
- **Arbitration:** both requesters continuously valid with 64-byte frames → grants alternate 0,1,0; `tx_en` low exactly 12 cycles between frames.
- **Error propagation:** `req_err` on payload byte 5 of 20 → `tx_er`=0 on bytes 0–4, 1 from byte 5 through the 4th FCS byte, 0 in IFG.
- **Underrun:** `req_valid` low for 2 cycles mid-payload → two 0x00 bytes with `tx_er`=1; `tx_er` stays 1 to frame end; total `tx_en` cycles increase by 2.
- **Reset mid-frame:** `rst_n` low during DATA → `tx_en`, `tx_er`, `req_ready`, `grant` go 0 without waiting for a clock; after release, the first request starts a clean preamble with pointer=0.
